subleq_sequencer: RTL and testbench
===================================

SUBLEQ_SEQUENCER -- requirements
Module: subleq_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width, two's complement.
REQ-002 SHALL have parameter ADDR_W, default 8: memory address width; ADDR_W <= WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  single-cycle pulse: begin execution at PC=0 from IDLE or HALT.
REQ-006 SHALL have port mem_en  output  1  BRAM enable.
REQ-007 SHALL have port mem_we  output  1  BRAM write enable.
REQ-008 SHALL have port mem_addr  output  ADDR_W  BRAM address.
REQ-009 SHALL have port mem_wdata  output  WIDTH  BRAM write data.
REQ-010 SHALL have port mem_rdata  input  WIDTH  BRAM read data, valid one cycle after the enabled read.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE and HALT.
REQ-012 SHALL have port halted  output  1  high in HALT.
REQ-013 SHALL have port pc  output  ADDR_W  current program counter.
REQ-014 SHALL have port retire  output  1  one-cycle pulse per completed instruction.

Function
REQ-015 SHALL run the FSM states IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, HALT.
REQ-016 SHALL in IDLE or HALT, on start=1: set pc=0 and enter FETCH_A; otherwise hold state.
REQ-017 SHALL in FETCH_A drive mem_en=1, mem_we=0, mem_addr=pc, then go to FETCH_B.
REQ-018 SHALL in FETCH_B drive a read at pc+1, latch A=mem_rdata[ADDR_W-1:0], then go to FETCH_C.
REQ-019 SHALL in FETCH_C drive a read at pc+2, latch B, then go to READ_A.
REQ-020 SHALL in READ_A drive a read at A, latch C, then go to READ_B.
REQ-021 SHALL in READ_B drive a read at B, latch VA=mem_rdata, then go to WRITE.
REQ-022 SHALL in WRITE drive mem_en=1, mem_we=1, mem_addr=B, mem_wdata=mem_rdata-VA (WIDTH bits, modulo 2^WIDTH, combinational from mem_rdata), and assert retire.
REQ-023 SHALL treat the branch as taken when the WRITE result is zero or its MSB is 1.
REQ-024 SHALL on leaving WRITE set pc=C if taken, else pc=pc+3.
REQ-025 SHALL go from WRITE to HALT if the branch is taken and C equals all-ones, else to FETCH_A.
REQ-026 SHALL perform all pc and address arithmetic (pc+1, pc+2, pc+3) modulo 2^ADDR_W.
REQ-027 SHALL take exactly 6 cycles per instruction, FETCH_A through WRITE inclusive.
REQ-028 SHALL in IDLE and HALT drive mem_en=0 and mem_we=0.
REQ-029 SHALL drive mem_we=1 only in WRITE.
REQ-030 SHALL ignore start while busy=1.
REQ-031 SHALL in HALT hold pc at C, the halt address.
REQ-032 SHALL produce the correct result when A==B: the result is 0, so the branch is taken.
REQ-033 SHALL handle self-modifying code with no forwarding: the write completes before the next FETCH_A read.

Reset
REQ-034 SHALL while rst_n=0 asynchronously force state=IDLE, pc=0, A=B=C=VA=0.
REQ-035 SHALL while rst_n=0 force mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, halted=0, retire=0.
REQ-036 SHALL on reset asserted mid-instruction, including during WRITE, abandon the instruction with no write issued after reset assertion.
REQ-037 SHALL require a start pulse after reset release before any memory access.

Verification
REQ-038 SHALL be verified: mem[0..2]={3,4,6}, mem[3]=5, mem[4]=7, start -> cycle 6 writes mem[4]=2 with retire=1, then pc=3, not taken.
REQ-039 SHALL be verified: mem[3]=7, mem[4]=7 with the same code -> mem[4]=0, taken, pc=6.
REQ-040 SHALL be verified: mem[3]=9, mem[4]=7 -> mem[4]=0xFE, taken via MSB, pc=6.
REQ-041 SHALL be verified: mem[0..2]={3,3,255} -> mem[3]=0, halted=1, busy=0, pc=255, mem_en=0 thereafter; a new start restarts at pc=0.
REQ-042 SHALL be verified: pc=254 (reached via branch) -> fetch addresses 254, 255, 0; non-taken next pc=1.
REQ-043 SHALL be verified: rst_n pulled low during WRITE -> mem_we drops immediately, busy=0, pc=0, no further accesses until start.

Source files
------------

// File: rtl/subleq_sequencer.sv
// SUBLEQ sequencer: fetches A, B, C from a synchronous-read BRAM, computes mem[B] -= mem[A]
// and branches to C when the result is <= 0. Branching to the all-ones address halts the core.
module subleq_sequencer #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic              retire
);

    typedef enum logic [2:0] {
        StIdle,
        StFetchA,
        StFetchB,
        StFetchC,
        StReadA,
        StReadB,
        StWrite,
        StHalt
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  a_q, a_d;
    logic [ADDR_W-1:0]  b_q, b_d;
    logic [ADDR_W-1:0]  c_q, c_d;
    logic [WIDTH-1:0]   va_q, va_d;

    logic [WIDTH-1:0]   result;
    logic               taken;

    // mem_rdata in WRITE is mem[B]; the subtraction wraps modulo 2^WIDTH
    assign result = mem_rdata - va_q;
    assign taken  = (result == '0) || result[WIDTH-1];

    assign busy   = (state_q != StIdle) && (state_q != StHalt);
    assign halted = (state_q == StHalt);
    assign pc     = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            va_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            va_q    <= va_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        va_d      = va_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;

        case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = StFetchA;
                end
            end
            StFetchA: begin
                mem_en   = 1'b1;
                mem_addr = pc_q;
                state_d  = StFetchB;
            end
            StFetchB: begin
                mem_en   = 1'b1;
                mem_addr = pc_q + ADDR_W'(1);
                a_d      = mem_rdata[ADDR_W-1:0];
                state_d  = StFetchC;
            end
            StFetchC: begin
                mem_en   = 1'b1;
                mem_addr = pc_q + ADDR_W'(2);
                b_d      = mem_rdata[ADDR_W-1:0];
                state_d  = StReadA;
            end
            StReadA: begin
                mem_en   = 1'b1;
                mem_addr = a_q;
                c_d      = mem_rdata[ADDR_W-1:0];
                state_d  = StReadB;
            end
            StReadB: begin
                mem_en   = 1'b1;
                mem_addr = b_q;
                va_d     = mem_rdata;
                state_d  = StWrite;
            end
            StWrite: begin
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = b_q;
                mem_wdata = result;
                retire    = 1'b1;
                if (taken) begin
                    pc_d = c_q;
                end else begin
                    pc_d = pc_q + ADDR_W'(3);
                end
                state_d = (taken && (c_q == {ADDR_W{1'b1}})) ? StHalt : StFetchA;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_subleq_sequencer.sv
// Bench for subleq_sequencer: BRAM model plus an instruction-level SUBLEQ reference,
// directed programs for the corner cases and randomized programs.
module tb_subleq_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       halted;
    logic [7:0] pc;
    logic       retire;

    logic [7:0] bram    [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ref_pc;
    int         vectors     = 0;
    int         miscompares = 0;

    subleq_sequencer #(
        .WIDTH  (8),
        .ADDR_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .halted    (halted),
        .pc        (pc),
        .retire    (retire)
    );

    always #5 clk = ~clk;

    // Read-first synchronous BRAM
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr] <= mem_wdata;
            mem_rdata <= bram[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, " mem_en"}, mem_en, 1'b0);
        check_eq({tag, " mem_we"}, mem_we, 1'b0);
        check_eq({tag, " busy"}, busy, 1'b0);
        check_eq({tag, " retire"}, retire, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_quiet("rst");
        check_eq("rst mem_addr", mem_addr, 8'h00);
        check_eq("rst mem_wdata", mem_wdata, 8'h00);
        check_eq("rst halted", halted, 1'b0);
        check_eq("rst pc", pc, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("post-rst idle");
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) bram[i] = 8'h00;
    endtask

    // Called at a negedge while idle/halted; leaves the bench at the negedge in FETCH_A
    task automatic start_prog();
        ref_pc = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = bram[i];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks one full instruction cycle by cycle against the reference and advances it
    task automatic run_instr(input bit poke_start, output bit halt_exp);
        logic [7:0] p1, p2, a, b, c, res, ea [6];
        bit         tk;
        p1  = ref_pc + 8'd1;
        p2  = ref_pc + 8'd2;
        a   = ref_mem[ref_pc];
        b   = ref_mem[p1];
        c   = ref_mem[p2];
        res = ref_mem[b] - ref_mem[a];
        tk  = (res == 8'h00) || res[7];
        ea[0] = ref_pc; ea[1] = p1; ea[2] = p2; ea[3] = a; ea[4] = b; ea[5] = b;
        for (int k = 0; k < 6; k++) begin
            check_eq($sformatf("pc%0h c%0d mem_en", ref_pc, k), mem_en, 1'b1);
            check_eq($sformatf("pc%0h c%0d mem_addr", ref_pc, k), mem_addr, ea[k]);
            check_eq($sformatf("pc%0h c%0d mem_we", ref_pc, k), mem_we, k == 5);
            check_eq($sformatf("pc%0h c%0d retire", ref_pc, k), retire, k == 5);
            check_eq($sformatf("pc%0h c%0d busy", ref_pc, k), busy, 1'b1);
            if (k == 5) check_eq($sformatf("pc%0h wdata", ref_pc), mem_wdata, res);
            start = poke_start ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        ref_mem[b] = res;
        ref_pc     = tk ? c : ref_pc + 8'd3;
        halt_exp   = tk && (c == 8'hFF);
        check_eq("next pc", pc, ref_pc);
        check_eq("halted", halted, halt_exp);
        check_eq("busy after", busy, !halt_exp);
    endtask

    task automatic check_mem_image(input string tag);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (bram[i] !== ref_mem[i]) bad++;
        check_eq({tag, " mem words differing"}, bad, 0);
    endtask

    initial begin
        bit         h;
        logic [7:0] wb, old;
        rst_n = 1'b1;
        start = 1'b0;
        clear_mem();
        apply_reset();

        // No access without a start pulse after reset
        repeat (4) @(negedge clk);
        check_quiet("no start");

        // mem[4] = 7 - 5 = 2, not taken
        bram[0] = 8'd3; bram[1] = 8'd4; bram[2] = 8'd6; bram[3] = 8'd5; bram[4] = 8'd7;
        start_prog();
        run_instr(1'b0, h);
        check_eq("d038 mem4", bram[4], 8'd2);
        check_eq("d038 pc", pc, 8'd3);

        apply_reset();
        bram[0] = 8'd3; bram[1] = 8'd4; bram[2] = 8'd6; bram[3] = 8'd7; bram[4] = 8'd7;
        start_prog();
        run_instr(1'b0, h);
        check_eq("d039 mem4", bram[4], 8'd0);
        check_eq("d039 pc", pc, 8'd6);

        apply_reset();
        bram[0] = 8'd3; bram[1] = 8'd4; bram[2] = 8'd6; bram[3] = 8'd9; bram[4] = 8'd7;
        start_prog();
        run_instr(1'b1, h);
        check_eq("d040 mem4", bram[4], 8'hFE);
        check_eq("d040 pc", pc, 8'd6);

        // A == B branch to all-ones halts; start in HALT restarts at 0
        apply_reset();
        clear_mem();
        bram[0] = 8'd3; bram[1] = 8'd3; bram[2] = 8'd255; bram[3] = 8'h55;
        start_prog();
        run_instr(1'b0, h);
        check_eq("d041 mem3", bram[3], 8'd0);
        check_eq("d041 pc", pc, 8'd255);
        repeat (3) begin
            check_quiet("d041 halted idle");
            check_eq("d041 halted hold", halted, 1'b1);
            @(negedge clk);
        end
        start_prog();
        check_eq("d041 restart addr", mem_addr, 8'd0);
        run_instr(1'b0, h);
        check_eq("d041 rehalt", halted, 1'b1);

        // Branch to 254, then fetch wraps 254, 255, 0; next pc = 1
        apply_reset();
        clear_mem();
        bram[0] = 8'd10; bram[1] = 8'd10; bram[2] = 8'd254;
        bram[254] = 8'd20; bram[255] = 8'd21; bram[20] = 8'd1; bram[21] = 8'd5;
        start_prog();
        run_instr(1'b0, h);
        check_eq("d042 pc254", pc, 8'd254);
        run_instr(1'b0, h);
        check_eq("d042 wrap pc", pc, 8'd1);
        check_eq("d042 mem21", bram[21], 8'd4);

        // Reset during WRITE must suppress the write
        apply_reset();
        bram[0] = 8'd3; bram[1] = 8'd4; bram[2] = 8'd6; bram[3] = 8'd5; bram[4] = 8'd7;
        start_prog();
        wb  = bram[1];
        old = bram[wb];
        repeat (5) @(negedge clk);
        check_eq("d043 in write", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check_quiet("d043 rst");
        check_eq("d043 pc", pc, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_quiet("d043 after rst");
        end
        check_eq("d043 no write", bram[wb], old);

        // Random programs, start poked while busy
        for (int t = 0; t < 24; t++) begin
            apply_reset();
            for (int i = 0; i < 256; i++) bram[i] = 8'($urandom);
            if (t % 3 == 0) bram[2] = 8'hFF;
            start_prog();
            for (int n = 0; n < 40; n++) begin
                run_instr(1'b1, h);
                if (h) break;
            end
            check_mem_image($sformatf("rand%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
